// File: rtl/mem_to_axi_master_if.sv
// AXI_BUS: AXI4 channel bundle with Master and Slave views.
//
// Parameters:
//    AXI_ADDR_WIDTH  address width of AW/AR
//    AXI_DATA_WIDTH  data width of W/R (strobe width is DATA/8)
//    AXI_ID_WIDTH    width of every id field
//    AXI_USER_WIDTH  width of every user field
// Modports:
//    Master  drives AW/W/AR payload and valids plus B/R readies
//    Slave   the mirror image
interface AXI_BUS #(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_ID_WIDTH   = 16,
   parameter int unsigned AXI_USER_WIDTH = 10
);
   localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

   logic [AXI_ID_WIDTH-1:0]   aw_id;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr;
   logic [7:0]                aw_len;
   logic [2:0]                aw_size;
   logic [1:0]                aw_burst;
   logic                      aw_lock;
   logic [3:0]                aw_cache;
   logic [2:0]                aw_prot;
   logic [3:0]                aw_qos;
   logic [3:0]                aw_region;
   logic [5:0]                aw_atop;
   logic [AXI_USER_WIDTH-1:0] aw_user;
   logic                      aw_valid;
   logic                      aw_ready;

   logic [AXI_DATA_WIDTH-1:0] w_data;
   logic [AXI_STRB_WIDTH-1:0] w_strb;
   logic                      w_last;
   logic [AXI_USER_WIDTH-1:0] w_user;
   logic                      w_valid;
   logic                      w_ready;

   logic [AXI_ID_WIDTH-1:0]   b_id;
   logic [1:0]                b_resp;
   logic [AXI_USER_WIDTH-1:0] b_user;
   logic                      b_valid;
   logic                      b_ready;

   logic [AXI_ID_WIDTH-1:0]   ar_id;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr;
   logic [7:0]                ar_len;
   logic [2:0]                ar_size;
   logic [1:0]                ar_burst;
   logic                      ar_lock;
   logic [3:0]                ar_cache;
   logic [2:0]                ar_prot;
   logic [3:0]                ar_qos;
   logic [3:0]                ar_region;
   logic [AXI_USER_WIDTH-1:0] ar_user;
   logic                      ar_valid;
   logic                      ar_ready;

   logic [AXI_ID_WIDTH-1:0]   r_id;
   logic [AXI_DATA_WIDTH-1:0] r_data;
   logic [1:0]                r_resp;
   logic                      r_last;
   logic [AXI_USER_WIDTH-1:0] r_user;
   logic                      r_valid;
   logic                      r_ready;

   modport Master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_atop, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );

   modport Slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
             aw_qos, aw_region, aw_atop, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
             ar_qos, ar_region, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );
endinterface

// File: rtl/mem_to_axi_master.sv
// mem_to_axi_master: bridges a req/gnt/rvalid memory port onto single-beat AXI4 transactions.
//
// Ports:
//    clk_i, rst_ni       clock, asynchronous active-low reset
//    mem_req_i/gnt_o     request handshake; gnt is combinational when idle
//    mem_addr_i/we_i/be_i/wdata_i  request payload, latched on grant
//    mem_rvalid_o        one-cycle completion pulse for reads and writes
//    mem_rdata_o/err_o   read data and response error, valid with rvalid
//    busy_o              high while a transaction is in flight
//    AXI_Master          AXI4 master port, one transaction outstanding
module mem_to_axi_master #(
   parameter int unsigned                AXI_ADDR_WIDTH = 32,
   parameter int unsigned                AXI_DATA_WIDTH = 32,
   parameter int unsigned                AXI_ID_WIDTH   = 16,
   parameter int unsigned                AXI_USER_WIDTH = 10,
   parameter logic [AXI_ID_WIDTH-1:0]    AXI_ID         = '0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        mem_req_i,
   output logic                        mem_gnt_o,
   input  logic [AXI_ADDR_WIDTH-1:0]   mem_addr_i,
   input  logic                        mem_we_i,
   input  logic [AXI_DATA_WIDTH/8-1:0] mem_be_i,
   input  logic [AXI_DATA_WIDTH-1:0]   mem_wdata_i,
   output logic                        mem_rvalid_o,
   output logic [AXI_DATA_WIDTH-1:0]   mem_rdata_o,
   output logic                        mem_err_o,
   output logic                        busy_o,
   AXI_BUS.Master                      AXI_Master
);
   localparam logic [2:0] SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

   typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_e;

   state_e                      state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [AXI_DATA_WIDTH/8-1:0] be_q, be_d;
   logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic aw_valid_q, aw_valid_d;
   logic w_valid_q, w_valid_d;
   logic b_ready_q, b_ready_d;
   logic ar_valid_q, ar_valid_d;
   logic r_ready_q, r_ready_d;
   logic rvalid_q, rvalid_d;
   logic err_q, err_d;
   logic unused_axi;

   assign mem_gnt_o    = (state_q == IDLE) & mem_req_i;
   assign busy_o       = state_q != IDLE;
   assign mem_rvalid_o = rvalid_q;
   assign mem_rdata_o  = rdata_q;
   assign mem_err_o    = err_q;

   // Only the error bit of the responses matters; single-beat R makes r_last redundant.
   assign unused_axi = ^{AXI_Master.b_id, AXI_Master.b_user, AXI_Master.b_resp[0],
                         AXI_Master.r_id, AXI_Master.r_user, AXI_Master.r_resp[0],
                         AXI_Master.r_last};

   // Each valid/ready clears itself on its own handshake, so in WRITE the valids
   // double as the aw_done/w_done flags and the two channels finish in any order.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      rvalid_d   = 1'b0;
      aw_valid_d = aw_valid_q & ~AXI_Master.aw_ready;
      w_valid_d  = w_valid_q & ~AXI_Master.w_ready;
      ar_valid_d = ar_valid_q & ~AXI_Master.ar_ready;
      b_ready_d  = b_ready_q & ~AXI_Master.b_valid;
      r_ready_d  = r_ready_q & ~AXI_Master.r_valid;
      case (state_q)
         IDLE: if (mem_req_i) begin
            addr_d     = mem_addr_i;
            be_d       = mem_be_i;
            wdata_d    = mem_wdata_i;
            state_d    = mem_we_i ? WRITE : RADDR;
            aw_valid_d = mem_we_i;
            w_valid_d  = mem_we_i;
            ar_valid_d = ~mem_we_i;
         end
         WRITE: if (!aw_valid_d && !w_valid_d) begin
            state_d   = WRESP;
            b_ready_d = 1'b1;
         end
         WRESP: if (AXI_Master.b_valid) begin
            state_d  = IDLE;
            rvalid_d = 1'b1;
            err_d    = AXI_Master.b_resp[1];
         end
         RADDR: if (AXI_Master.ar_ready) begin
            state_d   = RDATA;
            r_ready_d = 1'b1;
         end
         RDATA: if (AXI_Master.r_valid) begin
            state_d  = IDLE;
            rvalid_d = 1'b1;
            rdata_d  = AXI_Master.r_data;
            err_d    = AXI_Master.r_resp[1];
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         rvalid_q   <= 1'b0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         b_ready_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         r_ready_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         rvalid_q   <= rvalid_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         b_ready_q  <= b_ready_d;
         ar_valid_q <= ar_valid_d;
         r_ready_q  <= r_ready_d;
      end
   end

   assign AXI_Master.aw_id     = AXI_ID;
   assign AXI_Master.aw_addr   = addr_q;
   assign AXI_Master.aw_len    = 8'd0;
   assign AXI_Master.aw_size   = SIZE;
   assign AXI_Master.aw_burst  = 2'b01;
   assign AXI_Master.aw_lock   = 1'b0;
   assign AXI_Master.aw_cache  = 4'd0;
   assign AXI_Master.aw_prot   = 3'd0;
   assign AXI_Master.aw_qos    = 4'd0;
   assign AXI_Master.aw_region = 4'd0;
   assign AXI_Master.aw_atop   = 6'd0;
   assign AXI_Master.aw_user   = '0;
   assign AXI_Master.aw_valid  = aw_valid_q;

   assign AXI_Master.w_data    = wdata_q;
   assign AXI_Master.w_strb    = be_q;
   assign AXI_Master.w_last    = 1'b1;
   assign AXI_Master.w_user    = '0;
   assign AXI_Master.w_valid   = w_valid_q;

   assign AXI_Master.b_ready   = b_ready_q;

   assign AXI_Master.ar_id     = AXI_ID;
   assign AXI_Master.ar_addr   = addr_q;
   assign AXI_Master.ar_len    = 8'd0;
   assign AXI_Master.ar_size   = SIZE;
   assign AXI_Master.ar_burst  = 2'b01;
   assign AXI_Master.ar_lock   = 1'b0;
   assign AXI_Master.ar_cache  = 4'd0;
   assign AXI_Master.ar_prot   = 3'd0;
   assign AXI_Master.ar_qos    = 4'd0;
   assign AXI_Master.ar_region = 4'd0;
   assign AXI_Master.ar_user   = '0;
   assign AXI_Master.ar_valid  = ar_valid_q;

   assign AXI_Master.r_ready   = r_ready_q;
endmodule

// File: doc/mem_to_axi_master.md
Name: mem_to_axi_master

Overview:
- Initiator-side bridge: converts a core-style req/gnt/rvalid memory port into single-beat AXI4 transactions on an AXI_BUS.Master port.
- Lets a local master (core LSU, DMA stub, debug) reach AXI slaves such as the memory-mapped UART.
- Keeps exactly one transaction outstanding; no bursts, no reordering.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width; also the mem_addr_i width.
- AXI_DATA_WIDTH, 32, AXI data width; also the mem_wdata_i and mem_rdata_o width.
- AXI_ID_WIDTH, 16, AXI ID width.
- AXI_USER_WIDTH, 10, AXI user width; all user fields are driven 0.
- AXI_ID, 0, fixed ID driven on AW and AR.

Ports:
- clk_i  input  1  single clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- mem_req_i  input  1  request valid.
- mem_gnt_o  output  1  request accepted this cycle.
- mem_addr_i  input  AXI_ADDR_WIDTH  byte address.
- mem_we_i  input  1  1 = write, 0 = read.
- mem_be_i  input  AXI_DATA_WIDTH/8  byte enables, driven on W strb.
- mem_wdata_i  input  AXI_DATA_WIDTH  write data.
- mem_rvalid_o  output  1  one-cycle completion pulse, for reads and writes.
- mem_rdata_o  output  AXI_DATA_WIDTH  read data; valid while mem_rvalid_o is high.
- mem_err_o  output  1  response error; valid while mem_rvalid_o is high.
- busy_o  output  1  high whenever the FSM is not IDLE.
- AXI_Master  interface  AXI_BUS.Master  AXI4 master port.

Behaviour:
- Reset (asynchronous, on rst_ni low):
  - FSM returns to IDLE; aw_valid, w_valid, b_ready, ar_valid, r_ready, mem_rvalid_o, mem_err_o and busy_o all go to 0; mem_rdata_o and the latches go to 0.
  - A transaction in flight when reset asserts is abandoned. The AXI fabric is reset by the same signal.
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA.
- Grant:
  - mem_gnt_o = (state==IDLE) & mem_req_i, combinational.
  - On a grant, addr, we, be and wdata are latched and the FSM moves to WRITE (we=1) or RADDR (we=0).
- WRITE:
  - aw_valid and w_valid both rise in the cycle after the grant.
  - Each is lowered independently after its own handshake (valid & ready), tracked by aw_done and w_done flags.
  - AW and W may complete in either order or in the same cycle.
  - When both have completed (including the same cycle), go to WRESP.
- WRESP: b_ready=1. On b_valid, mem_err_o is registered as (b_resp[1]==1), i.e. SLVERR or DECERR; mem_rvalid_o pulses the next cycle; FSM goes to IDLE.
- RADDR: ar_valid=1; on ar_ready, go to RDATA.
- RDATA:
  - r_ready=1. On r_valid, latch r_data into mem_rdata_o and r_resp[1] into mem_err_o; mem_rvalid_o pulses the next cycle; FSM goes to IDLE.
  - r_last is ignored; a single beat is always expected.
- Back-to-back: a new request can be granted in the same cycle that mem_rvalid_o is high.
- Minimum latency with AXI ready/valid all high: grant at cycle 0, AW/W or AR at cycle 1, B or R at cycle 2, mem_rvalid_o at cycle 3.
- AXI valid/payload rule: once a valid is raised, it and its payload stay stable until ready. Payload outputs hold the latched values at all times.
- AW/AR fields:
  - id=AXI_ID, len=0, size=$clog2(AXI_DATA_WIDTH/8), burst=INCR (2'b01).
  - lock, cache, prot, qos, region and user are 0; aw_atop=0.
- W fields: strb=latched be, last=1, user=0.
- mem_be_i==0 is still issued as a write with strb=0; it completes normally.
- Unexpected b_valid or r_valid outside WRESP/RDATA is not accepted (ready held low).

Test Plan:
- Write 0x10000000 ← 0x00000041, be=4'hF, slave always ready, OKAY → AW addr 0x10000000, len 0, size 2, W data 0x41, strb F, last 1; mem_rvalid_o at cycle 3, err 0.
- Read 0x10000004, slave returns 0xDEADBEEF OKAY after 4 stall cycles on ar_ready and 2 on r_valid → ar_valid held stable throughout, mem_rdata_o 0xDEADBEEF, one-cycle pulse, err 0.
- Write where w_ready comes 3 cycles before aw_ready, then the reverse order → each valid drops only after its own handshake, exactly one AW and one W, then b_ready.
- Read returning r_resp=2'b11 (DECERR) → mem_err_o=1 with mem_rvalid_o; next OKAY write → err 0.
- Back-to-back: req held high for write then read → second gnt in the same cycle as the first mem_rvalid_o; no lost or duplicated AXI transaction.
- rst_ni pulled low while in WRITE with aw_valid high → aw_valid, w_valid and busy_o go to 0 immediately; after release, gnt_o asserts on the next req.
